// File: rtl/conv_pim_scheduler.sv
// Frame sequencer for the 5x5 bit-serial PIM convolution array: accepts windows, sweeps every
// stored-kernel address per window, waits the array latency and hands each result downstream.
module conv_pim_scheduler #(
    parameter int NUM_ADDR = 6,
    parameter int ADDR_W   = 5,
    parameter int PIM_LAT  = 1,
    parameter int DATA_W   = 18,
    parameter int WIN_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [WIN_W-1:0]  i_cfg_num_win,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_win_ld,
    output logic              o_pim_en,
    output logic [ADDR_W-1:0] o_pim_addr,
    input  logic [DATA_W-1:0] i_pim_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_last
);

    localparam int LAT_W = (PIM_LAT > 1) ? $clog2(PIM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_WIN, S_ISSUE, S_WAIT_LAT, S_OUT, S_DONE
    } state_t;

    state_t            r_state, w_nxt;
    logic [WIN_W-1:0]  r_num_win;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_data;

    logic w_lat_end, w_addr_end, w_win_end, w_accept;

    assign w_lat_end  = (r_lat_cnt == LAT_W'(PIM_LAT - 1));
    assign w_addr_end = (r_addr == ADDR_W'(NUM_ADDR - 1));
    assign w_win_end  = ((r_win_cnt + WIN_W'(1)) == r_num_win);
    assign w_accept   = (r_state == S_OUT) && i_out_ready;

    // All handshake/status outputs decode the state register, so an async reset clears them at once.
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_in_ready  = (r_state == S_WAIT_WIN);
    assign o_win_ld    = o_in_ready && i_in_valid;
    assign o_pim_en    = (r_state == S_ISSUE);
    assign o_pim_addr  = r_addr;
    assign o_out_valid = (r_state == S_OUT);
    assign o_out_data  = r_data;
    assign o_out_addr  = r_addr;
    assign o_out_last  = o_out_valid && w_addr_end && w_win_end;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_nxt = (i_cfg_num_win == '0) ? S_DONE : S_WAIT_WIN;
            S_WAIT_WIN: if (i_in_valid) w_nxt = S_ISSUE;
            S_ISSUE:    w_nxt = S_WAIT_LAT;
            S_WAIT_LAT: if (w_lat_end) w_nxt = S_OUT;
            S_OUT: begin
                if (i_out_ready) begin
                    if (!w_addr_end)    w_nxt = S_ISSUE;
                    else if (w_win_end) w_nxt = S_DONE;
                    else                w_nxt = S_WAIT_WIN;
                end
            end
            S_DONE:     w_nxt = S_IDLE;
            default:    w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_num_win <= '0;
            r_win_cnt <= '0;
            r_addr    <= '0;
            r_lat_cnt <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_num_win <= i_cfg_num_win;
                r_win_cnt <= '0;
            end
            if (o_win_ld)
                r_addr <= '0;
            if (r_state == S_ISSUE)
                r_lat_cnt <= '0;
            // The array result is only guaranteed valid on the final latency cycle.
            if (r_state == S_WAIT_LAT) begin
                if (w_lat_end) r_data <= i_pim_data;
                else           r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (w_accept) begin
                if (!w_addr_end) r_addr <= r_addr + ADDR_W'(1);
                else             r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_pim_scheduler.sv
// Randomized bench for conv_pim_scheduler: a frame-level timing/content model plus a latency-accurate
// PIM array model that only presents a valid result PIM_LAT cycles after each compute enable.
module tb_conv_pim_scheduler;
    localparam int NA  = 6;
    localparam int AW  = 5;
    localparam int LAT = 2;
    localparam int DW  = 18;
    localparam int WW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] cfg = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] pim_data = '0;
    logic          busy, done, in_ready, win_ld, pim_en, out_valid, out_last;
    logic [AW-1:0] pim_addr, out_addr;
    logic [DW-1:0] out_data;

    conv_pim_scheduler #(.NUM_ADDR(NA), .ADDR_W(AW), .PIM_LAT(LAT), .DATA_W(DW), .WIN_W(WW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_num_win(cfg),
        .o_busy(busy), .o_done(done), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_win_ld(win_ld), .o_pim_en(pim_en), .o_pim_addr(pim_addr), .i_pim_data(pim_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_addr(out_addr), .o_out_last(out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] kres(input int w, input int a);
        return DW'((w * 37 + a * 1009 + 5) % 262144);
    endfunction

    // Frame model: times are cycle numbers; t_ev is the last window accept or result accept.
    int  cyc = 0;
    bit  active = 0, waiting = 0;
    int  nwin = 0, idx = 0, t_ev = 0, done_cyc = -10, cur_win = 0, g_win = 0;
    bit  pen   [1:LAT];
    int  paddr [1:LAT];
    bit  prev_en = 0;
    int  prev_addr = 0;

    function automatic bit ov_at(input int c);
        return active && !waiting && (c >= t_ev + 2 + LAT);
    endfunction

    task automatic clear_model();
        active = 0; waiting = 0; done_cyc = -10; prev_en = 0;
        for (int k = 1; k <= LAT; k++) begin pen[k] = 0; paddr[k] = 0; end
    endtask

    task automatic step();
        bit e_ov, e_en, e_rdy;
        @(posedge clk); cyc++; #1;
        for (int k = LAT; k >= 2; k--) begin pen[k] = pen[k-1]; paddr[k] = paddr[k-1]; end
        pen[1] = prev_en; paddr[1] = prev_addr;
        pim_data  = pen[LAT] ? kres(cur_win, paddr[LAT]) : DW'($urandom);
        start     = ($urandom_range(0, 9) == 0);
        cfg       = WW'($urandom_range(0, 3));
        in_valid  = $urandom_range(0, 1);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        e_ov  = ov_at(cyc);
        e_en  = active && !waiting && (cyc == t_ev + 1);
        e_rdy = active && waiting;
        chk("busy", busy, active || cyc == done_cyc);
        chk("done", done, cyc == done_cyc);
        chk("in_ready", in_ready, e_rdy);
        chk("win_ld", win_ld, e_rdy && in_valid);
        chk("pim_en", pim_en, e_en);
        chk("out_valid", out_valid, e_ov);
        if (e_en) chk("pim_addr", pim_addr, idx % NA);
        if (e_ov) begin
            chk("out_addr", out_addr, idx % NA);
            chk("out_data", out_data, kres(cur_win, idx % NA));
            chk("out_last", out_last, idx == nwin * NA - 1);
        end
        if (!active && cyc != done_cyc && start) begin
            if (cfg == 0) done_cyc = cyc + 1;
            else begin active = 1; waiting = 1; nwin = int'(cfg); idx = 0; end
        end else if (e_rdy && in_valid) begin
            waiting = 0; t_ev = cyc; g_win++; cur_win = g_win;
        end else if (e_ov && out_ready) begin
            idx++; t_ev = cyc;
            if (idx % NA == 0) begin
                if (idx == nwin * NA) begin active = 0; done_cyc = cyc + 1; end
                else waiting = 1;
            end
        end
        prev_en = pim_en; prev_addr = int'(pim_addr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_win_ld"}, win_ld, 0);
        chk({tag, "_pim_en"}, pim_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        int guard;
        clear_model();
        @(posedge clk); @(posedge clk); cyc += 2; #1;
        chk_all_zero("rst0");
        chk("rst0_out_data", out_data, 0);
        chk("rst0_pim_addr", pim_addr, 0);
        chk("rst0_out_addr", out_addr, 0);
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) step();

        // Drive into a result-presenting cycle, then hit reset there.
        guard = 0;
        while (!ov_at(cyc + 1) && guard < 400) begin step(); guard++; end
        if (guard >= 400) chk("reach_out_timeout", 1, 0);
        @(posedge clk); cyc++; #1;
        start = 0; in_valid = 0; out_ready = 0;
        #1;
        chk("pre_rst_out_valid", out_valid, ov_at(cyc));
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); cyc++; #1;
        rst = 1'b0;
        clear_model();

        for (int i = 0; i < 1500; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
